// File: rtl/saturn_fetch.sv
// saturn_fetch: instruction fetch unit for the Saturn core.
// Owns the program counter, prefetches nibbles from the memory bus into a
// small FIFO and presents them one at a time to the instruction decoder.
// Optional build macro SATURN_FETCH_STATS_EN adds stall/flush counters.
//
// Handshakes:
//   Decoder side: o_nib_valid is the "valid", i_inc_pc is the "ready". A
//   nibble is consumed only on a cycle where both are high; i_inc_pc with
//   o_nib_valid low has no effect. o_nibble/o_pc are stable while valid is
//   held and no consume occurs.
//   Bus side: o_bus_req is a level request with o_bus_addr held stable
//   until the cycle where i_bus_ack is high, which completes the read and
//   supplies i_bus_nibble. A PC load may drop o_bus_req without an ack.
module saturn_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [19:0] RESET_PC = 20'h00000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_halt,
  input  logic        i_inc_pc,
  input  logic        i_load_pc,
  input  logic [19:0] i_new_pc,
  output logic [19:0] o_pc,
  output logic [3:0]  o_nibble,
  output logic        o_nib_valid,
  output logic        o_bus_req,
  output logic [19:0] o_bus_addr,
  input  logic        i_bus_ack,
  input  logic [3:0]  i_bus_nibble
`ifdef SATURN_FETCH_STATS_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [15:0] o_flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // pc is the address of the FIFO head, fa the next fetch address;
  // fa always equals pc + count (mod 2^20).
  logic [19:0]   pc;
  logic [19:0]   fa;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [3:0]    mem [DEPTH];
  logic          bus_req;
  logic          push;
  logic          pop;
  logic          req_next;

  // Per-cycle push/pop decisions and next request level.
  always_comb begin
    push       = bus_req && i_bus_ack;
    pop        = o_nib_valid && i_inc_pc;
    count_next = count + CW'(push) - CW'(pop);
    req_next   = 1'b0;
    if (i_load_pc) begin
      req_next = 1'b0;
    end else if (bus_req && !i_bus_ack) begin
      // An outstanding read is held (even under halt) until acked.
      req_next = 1'b1;
    end else begin
      req_next = !i_halt && (count_next < DEPTH_C);
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge i_clk) begin
    if (push && !i_load_pc) begin
      mem[wr_ptr] <= i_bus_nibble;
    end
  end

  // PC, fetch address, FIFO pointers and bus request; a load wins over
  // any simultaneous ack or consume and discards the acked nibble.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc      <= RESET_PC;
      fa      <= RESET_PC;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      bus_req <= 1'b0;
    end else if (i_load_pc) begin
      pc      <= i_new_pc;
      fa      <= i_new_pc;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      bus_req <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        fa     <= fa + 20'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        pc     <= pc + 20'd1;
      end
      count   <= count_next;
      bus_req <= req_next;
    end
  end

  assign o_nib_valid = (count != '0) && !i_halt;
  assign o_nibble    = (count != '0) ? mem[rd_ptr] : 4'h0;
  assign o_pc        = pc;
  assign o_bus_req   = bus_req;
  assign o_bus_addr  = fa;

`ifdef SATURN_FETCH_STATS_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  // Saturating counters of empty-FIFO stall cycles and PC-load flushes.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!i_halt && (count == '0) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (i_load_pc && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

  assign o_stall_cnt = stall_cnt;
  assign o_flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_saturn_fetch.sv
// Directed testbench for saturn_fetch (DEPTH=4, RESET_PC=0).
// Bus model: in zero-wait mode the ack follows o_bus_req combinationally;
// otherwise tasks pulse the ack by hand. Read data is always addr[3:0].
module tb_saturn_fetch;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        inc_pc;
  logic        load_pc;
  logic [19:0] new_pc;
  logic [19:0] pc;
  logic [3:0]  nibble;
  logic        nib_valid;
  logic        bus_req;
  logic [19:0] bus_addr;
  logic        bus_ack;
  logic [3:0]  bus_nibble;
  logic        zero_wait;
  logic        man_ack;
`ifdef SATURN_FETCH_STATS_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_cmp;
  int n_fail;

  assign bus_ack    = zero_wait ? bus_req : man_ack;
  assign bus_nibble = bus_addr[3:0];

  saturn_fetch #(.DEPTH(4), .RESET_PC(20'h00000)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_halt       (halt),
    .i_inc_pc     (inc_pc),
    .i_load_pc    (load_pc),
    .i_new_pc     (new_pc),
    .o_pc         (pc),
    .o_nibble     (nibble),
    .o_nib_valid  (nib_valid),
    .o_bus_req    (bus_req),
    .o_bus_addr   (bus_addr),
    .i_bus_ack    (bus_ack),
    .i_bus_nibble (bus_nibble)
`ifdef SATURN_FETCH_STATS_EN
    ,
    .o_stall_cnt  (stall_cnt),
    .o_flush_cnt  (flush_cnt)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int acks;
    logic [19:0] exp_addr;
    rst_n = 1'b0; halt = 1'b0; inc_pc = 1'b0; load_pc = 1'b0;
    new_pc = 20'h0; zero_wait = 1'b0; man_ack = 1'b0;
    repeat (3) step();
    n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", bus_req); end
    n_cmp++; if (nib_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", nib_valid); end
    n_cmp++; if (nibble !== 4'h0) begin n_fail++; $display("FAIL reset_nibble got=%h exp=0", nibble); end
    n_cmp++; if (pc !== 20'h00000) begin n_fail++; $display("FAIL reset_pc got=%h exp=00000", pc); end
    n_cmp++; if (bus_addr !== 20'h00000) begin n_fail++; $display("FAIL reset_addr got=%h exp=00000", bus_addr); end
    // Release with zero-wait bus, decoder not consuming.
    zero_wait = 1'b1;
    rst_n = 1'b1;
    step();
    n_cmp++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL first_req got=%b exp=1", bus_req); end
    n_cmp++; if (nib_valid !== 1'b0) begin n_fail++; $display("FAIL valid_cycle1 got=%b exp=0", nib_valid); end
    acks = 0;
    exp_addr = 20'h00000;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        n_cmp++; if (nib_valid !== 1'b1) begin n_fail++; $display("FAIL valid_cycle2 got=%b exp=1", nib_valid); end
        n_cmp++; if (pc !== 20'h00000) begin n_fail++; $display("FAIL pc_cycle2 got=%h exp=00000", pc); end
        n_cmp++; if (nibble !== 4'h0) begin n_fail++; $display("FAIL nibble_cycle2 got=%h exp=0", nibble); end
      end
      if (bus_req) begin
        n_cmp++; if (bus_addr !== exp_addr) begin n_fail++; $display("FAIL fill_addr got=%h exp=%h", bus_addr, exp_addr); end
        exp_addr = exp_addr + 20'd1;
        acks++;
      end
      if (k < 8) step();
    end
    n_cmp++; if (acks !== 4) begin n_fail++; $display("FAIL fill_acks got=%0d exp=4", acks); end
    n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL full_req got=%b exp=0", bus_req); end
  endtask

  task automatic test_consume_one();
    int reqs;
    inc_pc = 1'b1;
    step();
    inc_pc = 1'b0;
    n_cmp++; if (pc !== 20'h00001) begin n_fail++; $display("FAIL pop_pc got=%h exp=00001", pc); end
    n_cmp++; if (nibble !== 4'h1) begin n_fail++; $display("FAIL pop_nibble got=%h exp=1", nibble); end
    reqs = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus_req) begin
        reqs++;
        n_cmp++; if (bus_addr !== 20'h00004) begin n_fail++; $display("FAIL refill_addr got=%h exp=00004", bus_addr); end
      end
      step();
    end
    n_cmp++; if (reqs !== 1) begin n_fail++; $display("FAIL refill_count got=%0d exp=1", reqs); end
  endtask

  task automatic test_load_with_ack();
    // Pop once so a request (addr 5) is live and acked in the load cycle.
    inc_pc = 1'b1;
    step();
    inc_pc = 1'b0;
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 20'h00005) begin n_fail++; $display("FAIL preload_req got=%b/%h exp=1/00005", bus_req, bus_addr); end
    load_pc = 1'b1; new_pc = 20'h2ABCD;
    step();
    load_pc = 1'b0;
    n_cmp++; if (nib_valid !== 1'b0) begin n_fail++; $display("FAIL load_flush_valid got=%b exp=0", nib_valid); end
    n_cmp++; if (pc !== 20'h2ABCD) begin n_fail++; $display("FAIL load_pc got=%h exp=2ABCD", pc); end
    n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL load_req got=%b exp=0", bus_req); end
    step();
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 20'h2ABCD) begin n_fail++; $display("FAIL load_next_req got=%b/%h exp=1/2ABCD", bus_req, bus_addr); end
    n_cmp++; if (nib_valid !== 1'b0) begin n_fail++; $display("FAIL load_n1_valid got=%b exp=0", nib_valid); end
    step();
    n_cmp++; if (nib_valid !== 1'b1 || pc !== 20'h2ABCD || nibble !== 4'hD) begin
      n_fail++; $display("FAIL load_resume got=%b/%h/%h exp=1/2ABCD/D", nib_valid, pc, nibble);
    end
  endtask

  task automatic test_wrap();
    logic [19:0] exp_pc [4];
    logic [19:0] exp_ad [4];
    exp_pc[0] = 20'hFFFFE; exp_pc[1] = 20'hFFFFF; exp_pc[2] = 20'h00000; exp_pc[3] = 20'h00001;
    exp_ad[0] = 20'hFFFFF; exp_ad[1] = 20'h00000; exp_ad[2] = 20'h00001; exp_ad[3] = 20'h00002;
    load_pc = 1'b1; new_pc = 20'hFFFFE; inc_pc = 1'b1;
    step();
    load_pc = 1'b0;
    step();
    n_cmp++; if (bus_addr !== 20'hFFFFE) begin n_fail++; $display("FAIL wrap_first_addr got=%h exp=FFFFE", bus_addr); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (nib_valid !== 1'b1 || pc !== exp_pc[k]) begin n_fail++; $display("FAIL wrap_pc[%0d] got=%b/%h exp=1/%h", k, nib_valid, pc, exp_pc[k]); end
      n_cmp++; if (nibble !== exp_pc[k][3:0]) begin n_fail++; $display("FAIL wrap_nibble[%0d] got=%h exp=%h", k, nibble, exp_pc[k][3:0]); end
      n_cmp++; if (bus_addr !== exp_ad[k]) begin n_fail++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", k, bus_addr, exp_ad[k]); end
    end
    // Stop consuming and switch to the slow bus: read of addr 2 is now pending.
    inc_pc = 1'b0;
    zero_wait = 1'b0;
  endtask

  task automatic test_halt();
    step();
    halt = 1'b1;
    #1;
    n_cmp++; if (nib_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid got=%b exp=0", nib_valid); end
    step();
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 20'h00002) begin n_fail++; $display("FAIL halt_pending got=%b/%h exp=1/00002", bus_req, bus_addr); end
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    n_cmp++; if (bus_addr !== 20'h00003) begin n_fail++; $display("FAIL halt_pushed_addr got=%h exp=00003", bus_addr); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (bus_req !== 1'b0 || nib_valid !== 1'b0) begin n_fail++; $display("FAIL halt_idle[%0d] got=%b/%b exp=0/0", k, bus_req, nib_valid); end
      step();
    end
    n_cmp++; if (pc !== 20'h00001) begin n_fail++; $display("FAIL halt_pc got=%h exp=00001", pc); end
    halt = 1'b0;
    #1;
    n_cmp++; if (nib_valid !== 1'b1 || pc !== 20'h00001 || nibble !== 4'h1) begin
      n_fail++; $display("FAIL halt_resume got=%b/%h/%h exp=1/00001/1", nib_valid, pc, nibble);
    end
    step();
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 20'h00003) begin n_fail++; $display("FAIL halt_new_req got=%b/%h exp=1/00003", bus_req, bus_addr); end
  endtask

  task automatic test_reset_mid();
`ifdef SATURN_FETCH_STATS_EN
    n_cmp++; if (flush_cnt !== 16'd2) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=2", flush_cnt); end
`endif
    // Request for addr 3 is pending and a nibble is valid; pulse reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_req !== 1'b0 || nib_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset got=%b/%b exp=0/0", bus_req, nib_valid); end
    n_cmp++; if (pc !== 20'h00000 || bus_addr !== 20'h00000) begin n_fail++; $display("FAIL async_reset_pc got=%h/%h exp=00000/00000", pc, bus_addr); end
`ifdef SATURN_FETCH_STATS_EN
    n_cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0) begin n_fail++; $display("FAIL stats_clear got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
`endif
    zero_wait = 1'b1;
    rst_n = 1'b1;
    step();
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 20'h00000) begin n_fail++; $display("FAIL restart_req got=%b/%h exp=1/00000", bus_req, bus_addr); end
    step();
    n_cmp++; if (nib_valid !== 1'b1 || pc !== 20'h00000 || nibble !== 4'h0) begin
      n_fail++; $display("FAIL restart_valid got=%b/%h/%h exp=1/00000/0", nib_valid, pc, nibble);
    end
`ifdef SATURN_FETCH_STATS_EN
    n_cmp++; if (stall_cnt !== 32'd2) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=2", stall_cnt); end
`endif
  endtask

  // Sequencer and final report
  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_consume_one();
    test_load_with_ack();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
